// File: rtl/btb_set_assoc_pkg.sv
// Shared constants and helpers for the set-associative branch target buffer.
// Direction-counter storage is only present when BTB_COUNTER_EN is defined.
package btb_pkg;

   // Width of the per-entry direction counter
   localparam int CNT_W = 2;

   // Counter encodings; the MSB set means "predict taken"
   localparam logic [CNT_W-1:0] CNT_STRONG_NT = 2'd0;
   localparam logic [CNT_W-1:0] CNT_WEAK_T    = 2'd2;
   localparam logic [CNT_W-1:0] CNT_STRONG_T  = 2'd3;

   // Train a counter on a resolved outcome.
   // Jumps force strongly-taken; other outcomes saturate at both ends.
   function automatic logic [CNT_W-1:0] cnt_train(input logic [CNT_W-1:0] cnt,
                                                   input logic            taken,
                                                   input logic            jump);
      if (jump) begin
         return CNT_STRONG_T;
      end else if (taken) begin
         return (cnt == CNT_STRONG_T) ? cnt : cnt + 1'b1;
      end else begin
         return (cnt == CNT_STRONG_NT) ? cnt : cnt - 1'b1;
      end
   endfunction

endpackage

// File: rtl/btb_set_assoc_if.sv
// Fetch-side lookup and execute-side training signals of the BTB.
// master = fetch/execute pipeline, slave = the BTB itself.
interface btb_set_assoc_if #(
   parameter int ADDR_W = 64
);
   logic              en;
   logic              flush;
   logic [ADDR_W-1:0] lookup_pc;
   logic              pred_valid;
   logic [ADDR_W-1:0] pred_target;
   logic              upd_valid;
   logic [ADDR_W-1:0] upd_pc;
   logic [ADDR_W-1:0] upd_target;
   logic              upd_taken;
   logic              upd_is_jump;

   modport master (
      output en, flush, lookup_pc,
      output upd_valid, upd_pc, upd_target, upd_taken, upd_is_jump,
      input  pred_valid, pred_target
   );

   modport slave (
      input  en, flush, lookup_pc,
      input  upd_valid, upd_pc, upd_target, upd_taken, upd_is_jump,
      output pred_valid, pred_target
   );
endinterface

// File: rtl/btb_set_assoc_victim_sel.sv
// Replacement choice for one set: first invalid way if any, otherwise the
// round-robin way. The pointer only advances when a valid entry is evicted.
module btb_victim_sel #(
   parameter int WAYS  = 2,
   parameter int WAY_W = 1
) (
   input  logic [WAYS-1:0]  valid,
   input  logic [WAY_W-1:0] ptr,
   output logic [WAY_W-1:0] victim,
   output logic [WAY_W-1:0] ptr_next
);

   // Pick the lowest invalid way; fall back to the round-robin pointer
   always_comb begin
      victim   = ptr;
      ptr_next = ptr;
      for (int i = WAYS - 1; i >= 0; i--) begin
         if (!valid[i]) begin
            victim = WAY_W'(i);
         end
      end
      if (&valid) begin
         ptr_next = (ptr == WAY_W'(WAYS - 1)) ? '0 : ptr + 1'b1;
      end
   end

endmodule

// File: rtl/btb_set_assoc.sv
// N-way set-associative branch target buffer with registered prediction.
// Optional feature macro: BTB_COUNTER_EN adds 2-bit direction counters;
// without it every hit predicts taken and not-taken hits invalidate.
module btb_set_assoc
   import btb_pkg::*;
#(
   parameter int ADDR_W      = 64,
   parameter int INDEX_BITS  = 5,
   parameter int OFFSET_BITS = 2,
   parameter int WAYS        = 2
) (
   input  logic          clk,
   input  logic          arst_n,
   btb_set_assoc_if.slave bus
);

   localparam int TAG_W = ADDR_W - INDEX_BITS - OFFSET_BITS;
   localparam int SETS  = 1 << INDEX_BITS;
   localparam int WAY_W = (WAYS > 1) ? $clog2(WAYS) : 1;
   localparam int TAG_LO = OFFSET_BITS + INDEX_BITS;

   // State that must reset: valid bits, replacement pointers, outputs
   logic [WAYS-1:0]   valid_reg [SETS];
   logic [WAY_W-1:0]  rr_reg    [SETS];
   logic              pred_valid_reg;
   logic [ADDR_W-1:0] pred_target_reg;

   // Payload storage; contents are meaningless while the entry is invalid
   logic [TAG_W-1:0]  tag_mem    [SETS][WAYS];
   logic [ADDR_W-1:0] target_mem [SETS][WAYS];
`ifdef BTB_COUNTER_EN
   logic [CNT_W-1:0]  cnt_mem    [SETS][WAYS];
`endif

   logic [INDEX_BITS-1:0] lk_idx, up_idx;
   logic [TAG_W-1:0]      lk_tag, up_tag;
   logic [WAYS-1:0]       lk_hit_way, up_hit_way;
   logic                  lk_taken;
   logic [ADDR_W-1:0]     lk_target;
   logic [WAY_W-1:0]      up_way, victim_way, rr_next;
   logic                  up_hit, up_t, alloc, hit_upd;
   logic                  unused_lsbs;

   assign lk_idx = bus.lookup_pc[TAG_LO-1:OFFSET_BITS];
   assign lk_tag = bus.lookup_pc[ADDR_W-1:TAG_LO];
   assign up_idx = bus.upd_pc[TAG_LO-1:OFFSET_BITS];
   assign up_tag = bus.upd_pc[ADDR_W-1:TAG_LO];
   assign unused_lsbs = ^{bus.lookup_pc[OFFSET_BITS-1:0], bus.upd_pc[OFFSET_BITS-1:0]};

   generate
      for (genvar gi = 0; gi < WAYS; gi++) begin : g_way
         assign lk_hit_way[gi] = valid_reg[lk_idx][gi] && (tag_mem[lk_idx][gi] == lk_tag);
         assign up_hit_way[gi] = valid_reg[up_idx][gi] && (tag_mem[up_idx][gi] == up_tag);
      end
   endgenerate

   // Lookup read mux; a tag is never in two ways so at most one way hits
   always_comb begin
      lk_taken  = 1'b0;
      lk_target = '0;
      for (int w = 0; w < WAYS; w++) begin
         if (lk_hit_way[w]) begin
`ifdef BTB_COUNTER_EN
            lk_taken = cnt_mem[lk_idx][w][CNT_W-1];
`else
            lk_taken = 1'b1;
`endif
            lk_target = target_mem[lk_idx][w];
         end
      end
   end

   // Encode which way the training PC hits
   always_comb begin
      up_way = '0;
      for (int w = 0; w < WAYS; w++) begin
         if (up_hit_way[w]) begin
            up_way = WAY_W'(w);
         end
      end
   end

   assign up_hit  = |up_hit_way;
   assign up_t    = bus.upd_taken | bus.upd_is_jump;
   // Flush takes priority over training in the same cycle
   assign alloc   = bus.upd_valid && !bus.flush && !up_hit && up_t;
   assign hit_upd = bus.upd_valid && !bus.flush && up_hit;

   btb_victim_sel #(
      .WAYS  (WAYS),
      .WAY_W (WAY_W)
   ) u_victim_sel (
      .valid    (valid_reg[up_idx]),
      .ptr      (rr_reg[up_idx]),
      .victim   (victim_way),
      .ptr_next (rr_next)
   );

   // Prediction outputs, valid bits and replacement pointers
   always_ff @(posedge clk or negedge arst_n) begin
      if (!arst_n) begin
         pred_valid_reg  <= 1'b0;
         pred_target_reg <= '0;
         for (int s = 0; s < SETS; s++) begin
            valid_reg[s] <= '0;
            rr_reg[s]    <= '0;
         end
      end else begin
         if (bus.en) begin
            pred_valid_reg  <= lk_taken;
            pred_target_reg <= lk_taken ? lk_target : '0;
         end
         if (bus.flush) begin
            for (int s = 0; s < SETS; s++) begin
               valid_reg[s] <= '0;
               rr_reg[s]    <= '0;
            end
         end else if (alloc) begin
            valid_reg[up_idx][victim_way] <= 1'b1;
            rr_reg[up_idx]                <= rr_next;
         end
`ifndef BTB_COUNTER_EN
         else if (hit_upd && !up_t) begin
            valid_reg[up_idx][up_way] <= 1'b0;
         end
`endif
      end
   end

   // Payload writes: fill on allocate, retarget and retrain on hit
   always_ff @(posedge clk) begin
      if (alloc) begin
         tag_mem[up_idx][victim_way]    <= up_tag;
         target_mem[up_idx][victim_way] <= bus.upd_target;
`ifdef BTB_COUNTER_EN
         cnt_mem[up_idx][victim_way]    <= bus.upd_is_jump ? CNT_STRONG_T : CNT_WEAK_T;
`endif
      end else if (hit_upd) begin
         target_mem[up_idx][up_way] <= bus.upd_target;
`ifdef BTB_COUNTER_EN
         cnt_mem[up_idx][up_way]    <= cnt_train(cnt_mem[up_idx][up_way],
                                                 bus.upd_taken, bus.upd_is_jump);
`endif
      end
   end

   assign bus.pred_valid  = pred_valid_reg;
   assign bus.pred_target = pred_target_reg;

endmodule

// File: tb/tb_btb_set_assoc.sv
// Self-checking bench for btb_set_assoc: directed scenarios followed by
// randomized traffic, all compared against a behavioural table model.
module tb_btb_set_assoc;

   localparam int NS = 32;
   localparam int NW = 2;

   logic clk    = 1'b0;
   logic arst_n = 1'b0;
   always #5 clk = ~clk;

   btb_set_assoc_if #(.ADDR_W(64)) bus ();

   btb_set_assoc #(
      .ADDR_W      (64),
      .INDEX_BITS  (5),
      .OFFSET_BITS (2),
      .WAYS        (2)
   ) dut (
      .clk    (clk),
      .arst_n (arst_n),
      .bus    (bus)
   );

   int compared   = 0;
   int mismatched = 0;

   // Reference model: a table of entries per set, updated by the spec rules
   bit          m_v   [NS][NW];
   logic [63:0] m_tag [NS][NW];
   logic [63:0] m_tgt [NS][NW];
   int          m_cnt [NS][NW];
   int          m_rr  [NS];
   logic        exp_pv;
   logic [63:0] exp_pt;

   function automatic int set_of(input logic [63:0] pc);
      return int'(pc[6:2]);
   endfunction

   function automatic void m_reset();
      for (int s = 0; s < NS; s++) begin
         m_rr[s] = 0;
         for (int w = 0; w < NW; w++) m_v[s][w] = 1'b0;
      end
   endfunction

   function automatic void m_lookup(input logic [63:0] pc, output logic pv, output logic [63:0] pt);
      int s = set_of(pc);
      pv = 1'b0;
      pt = '0;
      for (int w = 0; w < NW; w++) begin
         if (m_v[s][w] && m_tag[s][w] == (pc >> 7)) begin
`ifdef BTB_COUNTER_EN
            pv = (m_cnt[s][w] >= 2);
`else
            pv = 1'b1;
`endif
            pt = pv ? m_tgt[s][w] : 64'd0;
         end
      end
   endfunction

   function automatic void m_update(input logic [63:0] pc, input logic [63:0] tgt,
                                    input logic tk, input logic jp);
      int s   = set_of(pc);
      int hw  = -1;
      int vic = -1;
      bit t   = tk | jp;
      for (int w = 0; w < NW; w++)
         if (m_v[s][w] && m_tag[s][w] == (pc >> 7)) hw = w;
      if (hw >= 0) begin
         m_tgt[s][hw] = tgt;
         if (jp)      m_cnt[s][hw] = 3;
         else if (t)  m_cnt[s][hw] = (m_cnt[s][hw] < 3) ? m_cnt[s][hw] + 1 : 3;
         else         m_cnt[s][hw] = (m_cnt[s][hw] > 0) ? m_cnt[s][hw] - 1 : 0;
`ifndef BTB_COUNTER_EN
         if (!t) m_v[s][hw] = 1'b0;
`endif
      end else if (t) begin
         for (int w = NW - 1; w >= 0; w--)
            if (!m_v[s][w]) vic = w;
         if (vic < 0) begin
            vic     = m_rr[s];
            m_rr[s] = (m_rr[s] + 1) % NW;
         end
         m_v[s][vic]   = 1'b1;
         m_tag[s][vic] = pc >> 7;
         m_tgt[s][vic] = tgt;
         m_cnt[s][vic] = jp ? 3 : 2;
      end
   endfunction

   task automatic chk1(input string tag, input logic got, input logic exp);
      compared++;
      assert (got === exp) else begin
         mismatched++;
         $error("FAIL %s: observed %0b expected %0b", tag, got, exp);
      end
   endtask

   task automatic chk64(input string tag, input logic [63:0] got, input logic [63:0] exp);
      compared++;
      assert (got === exp) else begin
         mismatched++;
         $error("FAIL %s: observed 0x%0h expected 0x%0h", tag, got, exp);
      end
   endtask

   // One clock of stimulus; outputs checked against the model 1ns after the edge
   task automatic step(input logic e, input logic fl, input logic [63:0] lpc,
                       input logic uv, input logic [63:0] upc, input logic [63:0] utgt,
                       input logic tk, input logic jp);
      bus.en          = e;
      bus.flush       = fl;
      bus.lookup_pc   = lpc;
      bus.upd_valid   = uv;
      bus.upd_pc      = upc;
      bus.upd_target  = utgt;
      bus.upd_taken   = tk;
      bus.upd_is_jump = jp;
      if (e) m_lookup(lpc, exp_pv, exp_pt);
      @(posedge clk);
      #1;
      if (fl)      m_reset();
      else if (uv) m_update(upc, utgt, tk, jp);
      chk1("pred_valid", bus.pred_valid, exp_pv);
      chk64("pred_target", bus.pred_target, exp_pt);
   endtask

   task automatic look(input logic [63:0] pc);
      step(1'b1, 1'b0, pc, 1'b0, 64'd0, 64'd0, 1'b0, 1'b0);
   endtask

   task automatic upd(input logic [63:0] pc, input logic [63:0] tgt, input logic tk, input logic jp);
      step(1'b0, 1'b0, 64'd0, 1'b1, pc, tgt, tk, jp);
   endtask

   function automatic logic [63:0] rand_pc();
      return 64'h10000 + (64'($urandom_range(0, 2)) << 7)
                       + (64'($urandom_range(0, 3)) << 2) + 64'($urandom_range(0, 3));
   endfunction

   initial begin
      bus.en = 1'b0; bus.flush = 1'b0; bus.lookup_pc = '0;
      bus.upd_valid = 1'b0; bus.upd_pc = '0; bus.upd_target = '0;
      bus.upd_taken = 1'b0; bus.upd_is_jump = 1'b0;
      m_reset();
      exp_pv = 1'b0;
      exp_pt = '0;

      // Reset state
      repeat (3) @(posedge clk);
      #1;
      chk1("reset_pv", bus.pred_valid, 1'b0);
      chk64("reset_pt", bus.pred_target, 64'd0);
      arst_n = 1'b1;

      // Cold lookup misses
      look(64'h1000);
      chk1("cold_miss", bus.pred_valid, 1'b0);

      // Train then hit
      upd(64'h1000, 64'h2000, 1'b1, 1'b0);
      look(64'h1000);
      chk1("hit_pv", bus.pred_valid, 1'b1);
      chk64("hit_pt", bus.pred_target, 64'h2000);

      // Three taken branches into set 0: third evicts way 0
      upd(64'h1080, 64'h2080, 1'b1, 1'b0);
      upd(64'h1100, 64'h2100, 1'b1, 1'b0);
      look(64'h1000);
      chk1("evicted_miss", bus.pred_valid, 1'b0);
      look(64'h1080);
      chk1("way1_hit", bus.pred_valid, 1'b1);
      look(64'h1100);
      chk64("alloc_hit_pt", bus.pred_target, 64'h2100);

      // Direction training (or invalidate on not-taken without counters)
      step(1'b0, 1'b1, 64'd0, 1'b0, 64'd0, 64'd0, 1'b0, 1'b0);
      upd(64'h1000, 64'h2000, 1'b1, 1'b0);
`ifdef BTB_COUNTER_EN
      upd(64'h1000, 64'h2000, 1'b0, 1'b0);
      upd(64'h1000, 64'h2000, 1'b0, 1'b0);
      look(64'h1000);
      chk1("cnt_nt", bus.pred_valid, 1'b0);
      upd(64'h1000, 64'h2000, 1'b1, 1'b0);
      look(64'h1000);
      chk1("cnt_one_t", bus.pred_valid, 1'b0);
      upd(64'h1000, 64'h2000, 1'b1, 1'b0);
      look(64'h1000);
      chk1("cnt_two_t", bus.pred_valid, 1'b1);
`else
      upd(64'h1000, 64'h2000, 1'b0, 1'b0);
      look(64'h1000);
      chk1("nt_invalidate", bus.pred_valid, 1'b0);
`endif

      // Same-cycle update and lookup sees pre-update state
      step(1'b1, 1'b0, 64'h3000, 1'b1, 64'h3000, 64'h3300, 1'b1, 1'b0);
      chk1("rbw_miss", bus.pred_valid, 1'b0);
      look(64'h3000);
      chk64("rbw_next_hit", bus.pred_target, 64'h3300);

      // Flush with simultaneous update: update dropped, everything misses
      for (int i = 0; i < 4; i++) upd(64'h5000 + 64'(i * 4), 64'h6000 + 64'(i), 1'b0, 1'b1);
      step(1'b1, 1'b1, 64'h5000, 1'b1, 64'h4000, 64'h4400, 1'b1, 1'b0);
      chk1("flush_cycle_prestate", bus.pred_valid, 1'b1);
      for (int i = 0; i < 4; i++) begin
         look(64'h5000 + 64'(i * 4));
         chk1("post_flush_miss", bus.pred_valid, 1'b0);
      end
      look(64'h4000);
      chk1("flush_drops_update", bus.pred_valid, 1'b0);

      // Reset mid-operation clears outputs at once
      upd(64'h7000, 64'h7700, 1'b1, 1'b1);
      look(64'h7000);
      #2 arst_n = 1'b0;
      #1;
      chk1("async_rst_pv", bus.pred_valid, 1'b0);
      chk64("async_rst_pt", bus.pred_target, 64'd0);
      m_reset();
      exp_pv = 1'b0;
      exp_pt = '0;
      @(posedge clk);
      #1 arst_n = 1'b1;
      look(64'h7000);
      chk1("post_rst_miss", bus.pred_valid, 1'b0);

      // Randomized traffic against the model
      for (int n = 0; n < 3000; n++) begin
         step(($urandom_range(0, 3) != 0), ($urandom_range(0, 49) == 0), rand_pc(),
              1'($urandom_range(0, 1)), rand_pc(), {$urandom, $urandom},
              1'($urandom_range(0, 1)), ($urandom_range(0, 3) == 0));
      end

      $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
      $finish;
   end

endmodule

// File: doc/btb_set_assoc.md
# btb_set_assoc

Parametrised set-associative branch target buffer for the fetch stage; successor of the direct-mapped single-way BTB. It looks up the fetch PC each enabled cycle and returns a registered target prediction one cycle later. It is trained from the execute stage with resolved branch/jump outcomes. Compared with its predecessor it adds N-way associativity, per-entry valid bits, round-robin replacement, optional 2-bit direction counters and a flush.

## Interface
- ADDR_W, 64, PC/target width
- INDEX_BITS, 5, set index width; 2**INDEX_BITS sets
- OFFSET_BITS, 2, PC LSBs ignored (instruction alignment)
- WAYS, 2, associativity; power of two, >= 1
- TAG_W, ADDR_W-INDEX_BITS-OFFSET_BITS, derived localparam, not overridable

- clk  in  1  clock, all state on rising edge
- arst_n  in  1  asynchronous active-low reset
- en  in  1  lookup enable (fetch not stalled)
- flush  in  1  invalidate all entries
- lookup_pc  in  ADDR_W  fetch PC
- pred_valid  out  1  registered: lookup hit, and predicts taken
- pred_target  out  ADDR_W  registered predicted target; 0 when pred_valid=0
- upd_valid  in  1  training strobe
- upd_pc  in  ADDR_W  PC of resolved branch/jump
- upd_target  in  ADDR_W  resolved target
- upd_taken  in  1  conditional branch resolved taken
- upd_is_jump  in  1  unconditional jump (treated as taken)

## Operation
- Index = pc[OFFSET_BITS+INDEX_BITS-1:OFFSET_BITS]; tag = pc[ADDR_W-1:OFFSET_BITS+INDEX_BITS].
- Entry: valid, tag, target, counter (counter only with BTB_COUNTER_EN).
- Lookup (en=1): hit = valid && tag match in some way. pred_valid <= hit && predicts-taken; pred_target <= hit target, else 0. With en=0, outputs hold.
- Update (upd_valid=1, independent of en). Effective taken T = upd_taken | upd_is_jump.
  - Tag hit: write target. Counter: jump -> 3; T -> sat-increment to 3; !T -> sat-decrement to 0.
  - Miss with T: allocate. Victim is the lowest-numbered invalid way; otherwise the way at the set's round-robin pointer, which then advances mod WAYS. New entry is valid; counter = 3 if jump, else 2.
  - Miss with !T: no change.
- Counter predicts taken when its MSB is 1.
- flush: clears all valid bits and round-robin pointers in one cycle. Targets and tags are don't-care.

## Timing
- Reset: pred_valid=0, pred_target=0, all valid=0, all pointers=0.
- Lookup latency 1 cycle: PC at edge k produces outputs after edge k+1.
- Update visible to lookups from the next edge. A same-cycle lookup to the same set sees pre-update state (read-before-write).
- flush and upd_valid in the same cycle: flush wins and the update is dropped. A lookup in the flush cycle still uses pre-flush state.
- Reset asserted mid-operation clears everything immediately; the first lookup after release misses.
- A tag can never occupy two ways: update checks hit before allocating.

## Configuration
- BTB_COUNTER_EN defined: per-entry 2-bit saturating counter gates pred_valid as above.
- Not defined: no counter storage. Every hit predicts taken. A not-taken update on a hit invalidates that entry; a not-taken miss does nothing.

## Structure
- Package btb_pkg: counter constants (CNT_STRONG_NT=0, CNT_WEAK_T=2, CNT_STRONG_T=3) and the counter width.
- One sub-module, btb_victim_sel: takes the set's valid vector and round-robin pointer, and outputs the victim way and the next pointer.

## Test plan
- Reset then lookup 0x1000 -> pred_valid=0, pred_target=0.
- Update pc=0x1000 target=0x2000 taken, then lookup 0x1000 -> next cycle pred_valid=1, pred_target=0x2000.
- Three taken branches to one set (INDEX_BITS=5, WAYS=2): pcs 0x1000, 0x1080, 0x1100.
  - The third evicts way 0 (0x1000).
  - Lookup 0x1000 then misses; lookups of 0x1080 and 0x1100 hit.
- With BTB_COUNTER_EN: allocate 0x1000 (counter 2), then two not-taken updates -> lookup gives pred_valid=0. One more taken update -> still 0. A second taken update -> pred_valid=1.
- Same-cycle update and lookup of new pc 0x3000 -> miss that cycle, hit on the following lookup.
- Populate 4 entries, assert flush with a simultaneous update to 0x4000 -> all lookups miss, including 0x4000.
